// File: rtl/sdhci_pkg.sv
// Shared SDHCI types: command layout, response types,
// arbiter FSM states and fixed command indices.
package sdhci_pkg;

  typedef struct packed {
    logic [5:0]  index;
    logic [1:0]  rsp_type;
    logic [31:0] arg;
  } sdhci_cmd_t;

  localparam logic [1:0] RSP_NONE = 2'b00;
  localparam logic [1:0] RSP_136  = 2'b01;
  localparam logic [1:0] RSP_48   = 2'b10;
  localparam logic [1:0] RSP_48B  = 2'b11;

  localparam logic [5:0] CMD12_IDX = 6'd12;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_SW_ISSUE   = 3'd1,
    ST_SW_WAIT    = 3'd2,
    ST_AC12_ISSUE = 3'd3,
    ST_AC12_WAIT  = 3'd4
  } arb_state_t;

  function automatic sdhci_cmd_t cmd12_stop();
    sdhci_cmd_t c;
    c.index    = CMD12_IDX;
    c.rsp_type = RSP_48B;
    c.arg      = 32'h0;
    return c;
  endfunction

endpackage

// File: rtl/sdhci_cmd_arbiter.sv
// Arbitrates software commands and Auto CMD12 onto the
// CMD line engine, tracks responses and timeouts.
module sdhci_cmd_arbiter #(
  parameter int RspTimeoutCycles = 64
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        sw_cmd_req_i,
  input  logic [39:0] sw_cmd_i,
  input  logic        xfer_done_i,
  input  logic        auto_cmd12_en_i,
  output logic        cmd_valid_o,
  input  logic        cmd_ready_i,
  output logic [39:0] cmd_o,
  input  logic        rsp_valid_i,
  input  logic [2:0]  rsp_err_i,
  output logic        cmd_inhibit_o,
  output logic        command_complete_o,
  output logic        transfer_complete_o,
  output logic [3:0]  cmd_err_o,
  output logic        cmd_err_de_o,
  output logic [4:0]  ac12_err_o,
  output logic        ac12_err_de_o
);
  import sdhci_pkg::*;

  localparam int CntW =
    (RspTimeoutCycles > 1) ? $clog2(RspTimeoutCycles) : 1;
  localparam logic [CntW-1:0] CntLast =
    CntW'(RspTimeoutCycles - 1);

  arb_state_t      state_q, state_d;
  logic            ac12_pend_q;
  logic            sw_pend_q;
  sdhci_cmd_t      sw_cmd_q;
  sdhci_cmd_t      cur_q;
  logic [CntW-1:0] cnt_q;

  logic       hs;
  logic       in_wait;
  logic       to_hit;
  logic       rsp_end;
  logic       timeout;
  logic [3:0] err4;
  logic       sw_hs;
  logic       ac_hs;
  logic       sw_nores;
  logic       sw_end;
  logic       ac_end;
  logic       ac_err;

  always_comb begin
    hs       = cmd_valid_o & cmd_ready_i;
    in_wait  = (state_q == ST_SW_WAIT) |
               (state_q == ST_AC12_WAIT);
    to_hit   = in_wait & (cnt_q == CntLast);
    rsp_end  = in_wait & (rsp_valid_i | to_hit);
    // A response in the last cycle beats the timeout.
    timeout  = to_hit & ~rsp_valid_i;
    err4     = {rsp_valid_i ? rsp_err_i : 3'b000, timeout};
    sw_hs    = (state_q == ST_SW_ISSUE) & hs;
    ac_hs    = (state_q == ST_AC12_ISSUE) & hs;
    sw_nores = sw_hs & (cur_q.rsp_type == RSP_NONE);
    sw_end   = (state_q == ST_SW_WAIT) & rsp_end;
    ac_end   = (state_q == ST_AC12_WAIT) & rsp_end;
    ac_err   = ac_end & (|err4);
  end

  always_comb begin
    cmd_valid_o = 1'b0;
    cmd_o       = '0;
    unique case (1'b1)
      state_q == ST_SW_ISSUE,
      state_q == ST_AC12_ISSUE: begin
        cmd_valid_o = 1'b1;
        cmd_o       = cur_q;
      end
      default: ;
    endcase
  end

  always_comb begin
    cmd_inhibit_o       = (state_q != ST_IDLE) | sw_pend_q;
    command_complete_o  = sw_nores | sw_end;
    cmd_err_de_o        = sw_end & (|err4);
    cmd_err_o           = cmd_err_de_o ? err4 : 4'b0000;
    ac12_err_de_o       = ac_err;
    ac12_err_o          = ac_err ? {sw_pend_q, err4} : 5'b0;
    transfer_complete_o = rst_ni &
      ((xfer_done_i & ~auto_cmd12_en_i) |
       (ac_end & ~(|err4)));
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (ac12_pend_q)    state_d = ST_AC12_ISSUE;
        else if (sw_pend_q) state_d = ST_SW_ISSUE;
      end
      ST_SW_ISSUE: begin
        if (sw_nores)   state_d = ST_IDLE;
        else if (hs)    state_d = ST_SW_WAIT;
      end
      ST_SW_WAIT: begin
        if (rsp_end)    state_d = ST_IDLE;
      end
      ST_AC12_ISSUE: begin
        if (hs)         state_d = ST_AC12_WAIT;
      end
      ST_AC12_WAIT: begin
        if (rsp_end)    state_d = ST_IDLE;
      end
      default:          state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      ac12_pend_q <= 1'b0;
      sw_pend_q   <= 1'b0;
      sw_cmd_q    <= '0;
      cur_q       <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      ac12_pend_q <= (xfer_done_i & auto_cmd12_en_i) |
                     (ac12_pend_q & ~ac_hs);
      // An errored CMD12 aborts the queued software command.
      sw_pend_q   <= sw_cmd_req_i |
                     (sw_pend_q & ~sw_hs & ~ac_err);
      if (sw_cmd_req_i) sw_cmd_q <= sw_cmd_i;
      if (state_q == ST_IDLE) begin
        if (ac12_pend_q)    cur_q <= cmd12_stop();
        else if (sw_pend_q) cur_q <= sw_cmd_q;
      end
      cnt_q <= (in_wait & ~rsp_end) ? cnt_q + 1'b1 : '0;
    end
  end

endmodule

// File: tb/tb_sdhci_cmd_arbiter.sv
// Scoreboard bench for sdhci_cmd_arbiter: directed
// scenarios push expected events, a monitor checks them.
module tb_sdhci_cmd_arbiter;

  localparam int EV_CMD  = 0;
  localparam int EV_CC   = 1;
  localparam int EV_CERR = 2;
  localparam int EV_AERR = 3;
  localparam int EV_TC   = 4;

  typedef struct {
    int          kind;
    logic [39:0] data;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        sw_cmd_req_i = 1'b0;
  logic [39:0] sw_cmd_i = '0;
  logic        xfer_done_i = 1'b0;
  logic        auto_cmd12_en_i = 1'b0;
  logic        cmd_valid_o;
  logic        cmd_ready_i = 1'b0;
  logic [39:0] cmd_o;
  logic        rsp_valid_i = 1'b0;
  logic [2:0]  rsp_err_i = '0;
  logic        cmd_inhibit_o;
  logic        command_complete_o;
  logic        transfer_complete_o;
  logic [3:0]  cmd_err_o;
  logic        cmd_err_de_o;
  logic [4:0]  ac12_err_o;
  logic        ac12_err_de_o;

  int total = 0;
  int bad = 0;
  ev_t exp_q[$];

  localparam logic [39:0] C12 = {6'd12, 2'b11, 32'h0};

  sdhci_cmd_arbiter #(.RspTimeoutCycles(64)) dut (
    .clk_i(clk),
    .rst_ni(rst_ni),
    .sw_cmd_req_i(sw_cmd_req_i),
    .sw_cmd_i(sw_cmd_i),
    .xfer_done_i(xfer_done_i),
    .auto_cmd12_en_i(auto_cmd12_en_i),
    .cmd_valid_o(cmd_valid_o),
    .cmd_ready_i(cmd_ready_i),
    .cmd_o(cmd_o),
    .rsp_valid_i(rsp_valid_i),
    .rsp_err_i(rsp_err_i),
    .cmd_inhibit_o(cmd_inhibit_o),
    .command_complete_o(command_complete_o),
    .transfer_complete_o(transfer_complete_o),
    .cmd_err_o(cmd_err_o),
    .cmd_err_de_o(cmd_err_de_o),
    .ac12_err_o(ac12_err_o),
    .ac12_err_de_o(ac12_err_de_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic expect_ev(input int k, input logic [39:0] d);
    ev_t e;
    e.kind = k;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic sb_chk(input int k, input logic [39:0] d);
    ev_t e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL unexpected event kind=%0d data=%h", k, d);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.data != d) begin
        bad++;
        $display("FAIL event got kind=%0d data=%h want kind=%0d data=%h",
                 k, d, e.kind, e.data);
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst_ni) begin
      if (cmd_valid_o && cmd_ready_i) sb_chk(EV_CMD, cmd_o);
      if (command_complete_o) sb_chk(EV_CC, '0);
      if (cmd_err_de_o) sb_chk(EV_CERR, 40'(cmd_err_o));
      if (ac12_err_de_o) sb_chk(EV_AERR, 40'(ac12_err_o));
      if (transfer_complete_o) sb_chk(EV_TC, '0);
    end
  end

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, act, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sw_req(input logic [39:0] c);
    sw_cmd_i = c;
    sw_cmd_req_i = 1'b1;
    tick();
    sw_cmd_req_i = 1'b0;
  endtask

  task automatic handshake(input int dly);
    int n = 0;
    while (!cmd_valid_o && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) begin
      total++;
      bad++;
      $display("FAIL cmd_valid wait got=0 want=1");
    end else begin
      repeat (dly) tick();
      cmd_ready_i = 1'b1;
      tick();
      cmd_ready_i = 1'b0;
    end
  endtask

  task automatic respond(input logic [2:0] err);
    rsp_valid_i = 1'b1;
    rsp_err_i = err;
    tick();
    rsp_valid_i = 1'b0;
    rsp_err_i = '0;
  endtask

  logic [39:0] c;
  logic seen;

  initial begin
    #3;
    check("reset_outs",
          64'({cmd_valid_o, cmd_o, cmd_inhibit_o,
               command_complete_o, transfer_complete_o,
               cmd_err_o, cmd_err_de_o, ac12_err_o,
               ac12_err_de_o}), 64'h0);
    tick();
    rst_ni = 1'b1;
    tick();
    check("idle_inhibit", 64'(cmd_inhibit_o), 64'h0);

    // Transfer done without Auto CMD12
    expect_ev(EV_TC, '0);
    xfer_done_i = 1'b1;
    tick();
    xfer_done_i = 1'b0;
    tick();

    // Clean R1 command
    c = {6'd17, 2'b10, 32'h200};
    expect_ev(EV_CMD, c);
    expect_ev(EV_CC, '0);
    sw_req(c);
    check("pend_inhibit", 64'(cmd_inhibit_o), 64'h1);
    handshake(3);
    repeat (4) tick();
    check("wait_inhibit", 64'(cmd_inhibit_o), 64'h1);
    respond(3'b000);
    check("done_inhibit", 64'(cmd_inhibit_o), 64'h0);

    // Response timeout
    c = {6'd13, 2'b10, 32'h1234};
    expect_ev(EV_CMD, c);
    expect_ev(EV_CC, '0);
    expect_ev(EV_CERR, 40'h1);
    sw_req(c);
    handshake(0);
    repeat (62) tick();
    check("to_cyc62_de", 64'(cmd_err_de_o), 64'h0);
    tick();
    check("to_cyc63", 64'({cmd_err_de_o, cmd_err_o}), 64'h11);
    tick();
    check("to_inhibit", 64'(cmd_inhibit_o), 64'h0);

    // Response coincident with timeout
    c = {6'd8, 2'b10, 32'h1aa};
    expect_ev(EV_CMD, c);
    expect_ev(EV_CC, '0);
    sw_req(c);
    handshake(1);
    repeat (63) tick();
    rsp_valid_i = 1'b1;
    #1;
    check("coinc_de", 64'(cmd_err_de_o), 64'h0);
    check("coinc_cc", 64'(command_complete_o), 64'h1);
    tick();
    rsp_valid_i = 1'b0;

    // Response error reported
    c = {6'd9, 2'b10, 32'h55};
    expect_ev(EV_CMD, c);
    expect_ev(EV_CC, '0);
    expect_ev(EV_CERR, 40'h4);
    sw_req(c);
    handshake(0);
    tick();
    respond(3'b010);

    // No-response command completes on handshake
    c = {6'd0, 2'b00, 32'h0};
    expect_ev(EV_CMD, c);
    expect_ev(EV_CC, '0);
    sw_req(c);
    handshake(0);
    check("nores_inhibit", 64'(cmd_inhibit_o), 64'h0);

    // Auto CMD12 ahead of software command
    c = {6'd18, 2'b10, 32'h400};
    expect_ev(EV_CMD, C12);
    expect_ev(EV_TC, '0);
    expect_ev(EV_CMD, c);
    expect_ev(EV_CC, '0);
    auto_cmd12_en_i = 1'b1;
    xfer_done_i = 1'b1;
    sw_req(c);
    xfer_done_i = 1'b0;
    handshake(1);
    repeat (2) tick();
    respond(3'b000);
    handshake(0);
    repeat (2) tick();
    respond(3'b000);
    tick();

    // Errored Auto CMD12 aborts pending software command
    c = {6'd25, 2'b10, 32'h800};
    expect_ev(EV_CMD, C12);
    expect_ev(EV_AERR, 40'h12);
    xfer_done_i = 1'b1;
    sw_req(c);
    xfer_done_i = 1'b0;
    handshake(0);
    tick();
    respond(3'b001);
    check("ac12err_inhibit", 64'(cmd_inhibit_o), 64'h0);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (cmd_valid_o) seen = 1'b1;
    end
    check("sw_never_offered", 64'(seen), 64'h0);
    auto_cmd12_en_i = 1'b0;

    // Reset during SW_WAIT
    c = {6'd7, 2'b10, 32'h7};
    expect_ev(EV_CMD, c);
    sw_req(c);
    handshake(0);
    repeat (2) tick();
    rst_ni = 1'b0;
    #1;
    check("rst_outs",
          64'({cmd_valid_o, cmd_o, cmd_inhibit_o,
               command_complete_o, transfer_complete_o,
               cmd_err_o, cmd_err_de_o, ac12_err_o,
               ac12_err_de_o}), 64'h0);
    tick();
    tick();
    rst_ni = 1'b1;
    respond(3'b111);
    repeat (70) tick();
    check("post_rst_inhibit", 64'(cmd_inhibit_o), 64'h0);

    check("queue_empty", 64'(exp_q.size()), 64'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
